// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip for a single hart behind a
// one-cycle request/response bus, producing an mip-layout pending vector.
// Optional debug-halt input `stop` is compiled in with CLINT_STOP_EN.
module clint #(
    parameter int unsigned TICK_DIV = 1,
    parameter bit          EXT_SYNC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rqst,
    input  logic        wen,
    input  logic [15:0] addr,
    input  logic [63:0] wdat,
    input  logic [7:0]  wmask,
    output logic        resp,
    output logic [63:0] rdat,
    output logic        err,
    input  logic        ext_irq,
    output logic [63:0] out_ip,
    output logic [63:0] out_time
`ifdef CLINT_STOP_EN
    ,
    input  logic        stop
`endif
);

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned MASK_W  = 8;
    localparam int unsigned PRESC_W = 16;

    localparam logic [ADDR_W-1:0]  OFF_MSIP     = 16'h0000;
    localparam logic [ADDR_W-1:0]  OFF_MTIMECMP = 16'h4000;
    localparam logic [ADDR_W-1:0]  OFF_MTIME    = 16'hBFF8;
    localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(TICK_DIV - 1);

    localparam int unsigned BIT_MSIP = 3;
    localparam int unsigned BIT_MTIP = 7;
    localparam int unsigned BIT_MEIP = 11;

    // architectural state
    logic [DATA_W-1:0]  mtime;
    logic [DATA_W-1:0]  mtimecmp;
    logic               msip;
    logic [PRESC_W-1:0] presc;
    logic               mtip_q;
    logic               meip_q;

    // decode / datapath helpers
    logic               sel_msip_c;
    logic               sel_cmp_c;
    logic               sel_time_c;
    logic               hit_c;
    logic               wr_msip_c;
    logic               wr_cmp_c;
    logic               wr_time_c;
    logic               halt_c;
    logic               tick_c;
    logic [DATA_W-1:0]  bmask_c;
    logic [DATA_W-1:0]  rd_val_c;

`ifdef CLINT_STOP_EN
    assign halt_c = stop;
`else
    assign halt_c = 1'b0;
`endif

    // byte-masked merge of write data into an existing register value
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                input logic [DATA_W-1:0] new_v,
                                                input logic [DATA_W-1:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    // address decode, write strobes and read mux; misaligned offsets never match
    always_comb begin
        sel_msip_c = (addr == OFF_MSIP);
        sel_cmp_c  = (addr == OFF_MTIMECMP);
        sel_time_c = (addr == OFF_MTIME);
        hit_c      = sel_msip_c | sel_cmp_c | sel_time_c;

        wr_msip_c  = rqst & wen & sel_msip_c;
        wr_cmp_c   = rqst & wen & sel_cmp_c;
        wr_time_c  = rqst & wen & sel_time_c;

        bmask_c = '0;
        for (int i = 0; i < int'(MASK_W); i++) begin
            bmask_c[8*i +: 8] = {8{wmask[i]}};
        end

        rd_val_c = '0;
        if (sel_msip_c) begin
            rd_val_c = {{(DATA_W-1){1'b0}}, msip};
        end else if (sel_cmp_c) begin
            rd_val_c = mtimecmp;
        end else if (sel_time_c) begin
            rd_val_c = mtime;
        end
    end

    // prescaler reaches its last count and counting is not halted
    assign tick_c = (presc == PRESC_LAST) && !halt_c;

    // prescaler and mtime; a bus write to mtime beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
            presc <= '0;
        end else if (wr_time_c) begin
            mtime <= merge(mtime, wdat, bmask_c);
            presc <= '0;
        end else if (!halt_c) begin
            if (tick_c) begin
                mtime <= mtime + 64'd1;
                presc <= '0;
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    // software-visible compare and soft-interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr_cmp_c) begin
                mtimecmp <= merge(mtimecmp, wdat, bmask_c);
            end
            if (wr_msip_c && wmask[0]) begin
                msip <= wdat[0];
            end
        end
    end

    // bus response: one cycle after every request, writes and faults return 0
    always_ff @(posedge clk) begin
        if (rst) begin
            resp <= 1'b0;
            rdat <= '0;
            err  <= 1'b0;
        end else begin
            resp <= rqst;
            err  <= rqst & ~hit_c;
            rdat <= (rqst && !wen && hit_c) ? rd_val_c : '0;
        end
    end

    // interrupt sources: level compare on current values, optional ext sync
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip_q <= 1'b0;
            meip_q <= 1'b0;
        end else begin
            mtip_q <= (mtime >= mtimecmp);
            meip_q <= ext_irq;
        end
    end

    // assemble the mip-layout pending vector
    always_comb begin
        out_ip           = '0;
        out_ip[BIT_MSIP] = msip;
        out_ip[BIT_MTIP] = mtip_q;
        out_ip[BIT_MEIP] = EXT_SYNC ? meip_q : ext_irq;
    end

    assign out_time = mtime;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a TICK_DIV=1 instance for bus/compare behaviour
// and a TICK_DIV=4 instance for prescaling and wrap-around.
module tb_clint;

    logic        clk;
    logic        rst;

    logic        rqst, wen;
    logic [15:0] addr;
    logic [63:0] wdat;
    logic [7:0]  wmask;
    logic        resp, err;
    logic [63:0] rdat;
    logic        ext_irq;
    logic [63:0] out_ip, out_time;
    logic        stop;

    logic        rqst4, wen4;
    logic [15:0] addr4;
    logic [63:0] wdat4;
    logic [7:0]  wmask4;
    logic        resp4, err4;
    logic [63:0] rdat4;
    logic [63:0] out_ip4, out_time4;
    logic        stop4;

    int tests;
    int fails;

    clint #(.TICK_DIV(1), .EXT_SYNC(1'b1)) dut (
        .clk(clk), .rst(rst), .rqst(rqst), .wen(wen), .addr(addr),
        .wdat(wdat), .wmask(wmask), .resp(resp), .rdat(rdat), .err(err),
        .ext_irq(ext_irq), .out_ip(out_ip), .out_time(out_time)
`ifdef CLINT_STOP_EN
        , .stop(stop)
`endif
    );

    clint #(.TICK_DIV(4), .EXT_SYNC(1'b1)) dut4 (
        .clk(clk), .rst(rst), .rqst(rqst4), .wen(wen4), .addr(addr4),
        .wdat(wdat4), .wmask(wmask4), .resp(resp4), .rdat(rdat4), .err(err4),
        .ext_irq(1'b0), .out_ip(out_ip4), .out_time(out_time4)
`ifdef CLINT_STOP_EN
        , .stop(stop4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [63:0] wdat;
        logic [7:0]  wmask;
        logic [63:0] exp_rdat;
        logic        exp_err;
        logic        exp_ip3;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus(input logic w, input logic [15:0] a, input logic [63:0] d,
                       input logic [7:0] m, output logic r, output logic [63:0] rd,
                       output logic e);
        @(negedge clk);
        rqst = 1'b1; wen = w; addr = a; wdat = d; wmask = m;
        @(negedge clk);
        r = resp; rd = rdat; e = err;
        rqst = 1'b0; wen = 1'b0;
    endtask

    logic        r_resp, r_err;
    logic [63:0] r_dat;
    logic [63:0] exp_t;
    logic        exp_ip;

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; rqst = 1'b0; wen = 1'b0; addr = '0; wdat = '0; wmask = '0;
        ext_irq = 1'b0; stop = 1'b0;
        rqst4 = 1'b0; wen4 = 1'b0; addr4 = '0; wdat4 = '0; wmask4 = '0; stop4 = 1'b0;

        vecs[0]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h4000, 64'h1234, 8'h03, 64'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_1234, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0010, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h4004, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 16'h4004, 64'h0, 8'hFF, 64'h0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_1234, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 16'h0000, 64'h3, 8'hFF, 64'h0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 16'h0000, 64'h0, 8'hFE, 64'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'h0000, 64'h0, 8'h01, 64'h0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h4000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, 64'h0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hAAAA_AAAA_FFFF_1234, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 16'hBFF9, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 16'h8000, 64'h5, 8'hFF, 64'h0, 1'b1, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_time", out_time, 64'd0);
        chk("rst_ip", out_ip, 64'd0);
        chk("rst_resp", 64'(resp), 64'd0);
        chk("rst_rdat", rdat, 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // free-running mtime and a read of mtime at cycle 5
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("time5", out_time, 64'd5);
        rqst = 1'b1; wen = 1'b0; addr = 16'hBFF8;
        @(negedge clk);
        rqst = 1'b0;
        chk("rd_time_resp", 64'(resp), 64'd1);
        chk("rd_time_rdat", rdat, 64'd5);
        chk("rd_time_err", 64'(err), 64'd0);
        repeat (4) @(negedge clk);
        chk("time10", out_time, 64'd10);
        chk("idle_resp", 64'(resp), 64'd0);

        // MTIP against mtimecmp = 20, then raise mtimecmp to clear it
        reset_all();
        repeat (3) @(negedge clk);
        chk("time3", out_time, 64'd3);
        rqst = 1'b1; wen = 1'b1; addr = 16'h4000; wdat = 64'd20; wmask = 8'hFF;
        @(negedge clk);
        rqst = 1'b0; wen = 1'b0;
        chk("wr_cmp_rdat", rdat, 64'd0);
        for (int i = 0; i < 40 && out_time != 64'd20; i++) @(negedge clk);
        chk("reach20", out_time, 64'd20);
        chk("mtip_pre", 64'(out_ip[7]), 64'd0);
        @(negedge clk);
        chk("mtip_rise", out_ip, 64'h80);
        rqst = 1'b1; wen = 1'b1; addr = 16'h4000; wdat = 64'd100; wmask = 8'hFF;
        @(negedge clk);
        rqst = 1'b0; wen = 1'b0;
        chk("mtip_old_cmp", 64'(out_ip[7]), 64'd1);
        @(negedge clk);
        chk("mtip_clear", 64'(out_ip[7]), 64'd0);

        // MEIP registered once
        ext_irq = 1'b1;
        @(negedge clk);
        chk("meip_set", out_ip, 64'h800);
        ext_irq = 1'b0;
        @(negedge clk);
        chk("meip_clr", 64'(out_ip[11]), 64'd0);

        // TICK_DIV = 4: prescaling, write collision and wrap-around
        reset_all();
        repeat (3) @(negedge clk);
        chk("div4_t3", out_time4, 64'd0);
        @(negedge clk);
        chk("div4_t4", out_time4, 64'd1);
        repeat (4) @(negedge clk);
        chk("div4_t8", out_time4, 64'd2);
        rqst4 = 1'b1; wen4 = 1'b1; addr4 = 16'hBFF8;
        wdat4 = 64'hFFFF_FFFF_FFFF_FFFE; wmask4 = 8'hFF;
        @(negedge clk);
        rqst4 = 1'b0; wen4 = 1'b0;
        chk("div4_wr", out_time4, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("div4_wr_resp", 64'(resp4), 64'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_t  = (k < 4) ? 64'hFFFF_FFFF_FFFF_FFFE :
                     (k < 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
            exp_ip = (k >= 5 && k <= 8);
            chk($sformatf("wrap_time_k%0d", k), out_time4, exp_t);
            chk($sformatf("wrap_mtip_k%0d", k), 64'(out_ip4[7]), 64'(exp_ip));
        end

        // register access table
        reset_all();
        for (int v = 0; v < NV; v++) begin
            bus(vecs[v].wen, vecs[v].addr, vecs[v].wdat, vecs[v].wmask, r_resp, r_dat, r_err);
            chk($sformatf("vec%0d_resp", v), 64'(r_resp), 64'd1);
            chk($sformatf("vec%0d_rdat", v), r_dat, vecs[v].exp_rdat);
            chk($sformatf("vec%0d_err", v), 64'(r_err), 64'(vecs[v].exp_err));
            chk($sformatf("vec%0d_ip3", v), 64'(out_ip[3]), 64'(vecs[v].exp_ip3));
        end

        // back-to-back reads of msip then mtimecmp
        @(negedge clk);
        rqst = 1'b1; wen = 1'b0; addr = 16'h0000;
        @(negedge clk);
        addr = 16'h4000;
        chk("b2b_0_resp", 64'(resp), 64'd1);
        chk("b2b_0_rdat", rdat, 64'd0);
        @(negedge clk);
        rqst = 1'b0;
        chk("b2b_1_resp", 64'(resp), 64'd1);
        chk("b2b_1_rdat", rdat, 64'hAAAA_AAAA_FFFF_1234);

        // reset arriving together with a request drops the response
        @(negedge clk);
        rqst = 1'b1; wen = 1'b0; addr = 16'hBFF8; rst = 1'b1;
        @(negedge clk);
        rqst = 1'b0; rst = 1'b0;
        chk("rst_mid_resp", 64'(resp), 64'd0);
        chk("rst_mid_rdat", rdat, 64'd0);
        chk("rst_mid_time", out_time, 64'd0);

`ifdef CLINT_STOP_EN
        // debug halt freezes mtime but bus writes still land
        reset_all();
        repeat (3) @(negedge clk);
        chk("stop_pre", out_time, 64'd3);
        stop = 1'b1;
        repeat (2) @(negedge clk);
        chk("stop_hold", out_time, 64'd3);
        rqst = 1'b1; wen = 1'b1; addr = 16'hBFF8; wdat = 64'd7; wmask = 8'hFF;
        @(negedge clk);
        rqst = 1'b0; wen = 1'b0;
        chk("stop_wr", out_time, 64'd7);
        repeat (2) @(negedge clk);
        chk("stop_hold7", out_time, 64'd7);
        stop = 1'b0;
        @(negedge clk);
        chk("stop_resume", out_time, 64'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor. The memory-mapped timer/software-interrupt source that feeds the CSR block's `in_time` and `in_ip` inputs.
- Holds `mtime`, `mtimecmp` and `msip` for a single hart, reachable through a simple request/response bus from the load/store path.
- Drives MTIP, MSIP and MEIP (MEIP passed through from outside) as an `mip`-layout vector.

Parameters:
- TICK_DIV, 1, number of `clk` cycles per `mtime` increment (legal range 1..65535).
- EXT_SYNC, 1, when 1, `ext_irq` is registered once before reaching `out_ip[11]`; when 0 it is a combinational pass-through.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rqst  input  1  bus request valid, accepted every cycle, no backpressure
- wen  input  1  1 = write, 0 = read
- addr  input  16  byte offset within CLINT window
- wdat  input  64  write data
- wmask  input  8  byte enables for writes
- resp  output  1  response valid, exactly 1 cycle after an accepted `rqst`
- rdat  output  64  read data, valid when `resp`
- err  output  1  access fault, valid when `resp`
- ext_irq  input  1  external interrupt line from the PLIC side
- out_ip  output  64  pending vector: bit 3 MSIP, bit 7 MTIP, bit 11 MEIP, all other bits 0
- out_time  output  64  current `mtime`
- stop  input  1  present only with CLINT_STOP_EN

Behaviour:
- Reset: one clock, `clk`; reset is synchronous and active-high, port `rst`. On reset:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, prescaler = 0.
  - `resp` = 0, `rdat` = 0, `err` = 0, `out_ip` = 0, `out_time` = 0.
- Reset mid-transaction: the pending response is dropped and `resp` is 0 in the cycle after reset.
- Address map (8-byte aligned registers):
  - 0x0000 `msip`: bit 0 is the only storage bit; reads return 0 in bits 63:1.
  - 0x4000 `mtimecmp`.
  - 0xBFF8 `mtime`.
- Faults: an unmapped offset, or `addr[2:0]` != 0, gives `err` = 1 and `rdat` = 0, with no state change.
- Bus timing:
  - A request in cycle N produces `resp` = 1 in cycle N+1.
  - A read returns the register value sampled in cycle N, before cycle N's `mtime` increment.
  - A write returns `rdat` = 0.
  - Back-to-back requests are allowed every cycle.
- Writes: the new value is `(old & ~M) | (wdat & M)`, where M is `wmask` expanded to bytes. The write takes effect at the end of cycle N.
- Prescaler:
  - A 16-bit counter increments each cycle.
  - When it equals TICK_DIV-1 it clears and `mtime` increments by 1.
  - With TICK_DIV = 1, `mtime` increments every cycle.
- `mtime` write collision: a write to `mtime` in the same cycle as an increment wins; the written value is stored and the prescaler clears to 0.
- Wrap-around: `mtime` wraps from 2^64-1 to 0 (modulo 2^64, no flag).
- MTIP:
  - Registered: `out_ip[7]` in cycle N+1 = (`mtime` >= `mtimecmp`), unsigned, using cycle-N register values.
  - Level-sensitive, not latched: it clears only when `mtimecmp` is raised above `mtime` or `mtime` wraps.
- MSIP: `out_ip[3]` = `msip` register bit 0; it follows a write one cycle after the request.
- MEIP: `out_ip[11]` = `ext_irq` registered (EXT_SYNC = 1) or direct (EXT_SYNC = 0).
- `out_time` equals the `mtime` register at every cycle.

Optional Feature:
- Macro: CLINT_STOP_EN.
- Defined:
  - Port `stop` exists.
  - While `stop` = 1, the prescaler and `mtime` hold their values (used for debug halt).
  - Bus writes to `mtime` still take effect.
  - MTIP is still evaluated each cycle.
- Undefined: the `stop` port is absent and counting never halts.

Test Plan:
- Reset, TICK_DIV = 1: `out_time` = 0, `out_ip` = 0; after 10 cycles `out_time` = 10; read 0xBFF8 at cycle 5 -> `resp` at cycle 6 with `rdat` = 5.
- Write `mtimecmp` = 20 (`wmask` = 8'hFF) with `mtime` = 3: `out_ip[7]` rises in the cycle after `mtime` reaches 20; write `mtimecmp` = 100 -> `out_ip[7]` = 0 one cycle later.
- TICK_DIV = 4: `mtime` increments once every 4 cycles; write `mtime` = 64'hFFFF_FFFF_FFFF_FFFE -> value reaches 0 after 8 further cycles with `mtimecmp` = all-ones; `out_ip[7]` is 1 while `mtime` = 2^64-1 and drops after the wrap.
- Write `msip` with `wdat` = 64'h3, then read 0x0000 -> `rdat` = 1 and `out_ip[3]` = 1; write 0 -> `out_ip[3]` = 0.
- Partial write: `mtimecmp` = all-ones, write `wdat` = 64'h1234 with `wmask` = 8'h03 -> read returns 64'hFFFF_FFFF_FFFF_1234; read 0x0010 -> `err` = 1, `rdat` = 0; read 0x4004 -> `err` = 1.
- With CLINT_STOP_EN: hold `stop` for 5 cycles -> `out_time` is frozen; a write to `mtime` = 7 during the stop is visible as 7 on `out_time`; assert `rst` with a read outstanding -> `resp` = 0 the following cycle.
